cache_writeback: RTL and testbench

- Evicts one dirty 8-word cache line from the cache data array to main memory.
- Sits upstream of the line-refill (allocate) stage: the cache controller pulses start on a dirty miss and waits for done, then launches the refill.
- Reads the cache data array (synchronous read, 1-cycle latency) and writes main memory one word per cycle.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_writeback.sv | 139 +++++++++++++
 tb/tb_cache_writeback.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths and write-back FSM encoding for the cache line movers.
package cache_pkg;

  localparam int DATA_W         = 32;
  localparam int INDEX_W        = 6;
  localparam int TAG_W          = 4;
  localparam int WORD_W         = 3;
  localparam int WORDS_PER_LINE = 2 ** WORD_W;
  localparam int CADDR_W        = INDEX_W + WORD_W;
  localparam int MADDR_W        = TAG_W + INDEX_W + WORD_W;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_PRIME = 2'd1,
    WB_WRITE = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/cache_writeback.sv
// Evicts one dirty 8-word line from the cache data array to main memory.
// Optional CACHE_WB_CLEAN_SKIP_EN: a start with dirty=0 goes straight to DONE.
//
// state | meaning
// IDLE  | waiting for start, counter held at 0
// PRIME | first cache read in flight, first memory write registered
// WRITE | one memory write per cycle, counter 0..7
// DONE  | transfer finished, done pulses on the following cycle
module cache_writeback
  import cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [TAG_W-1:0]   i_victim_tag,
  input  logic [INDEX_W-1:0] i_index,
  input  logic               i_dirty,
  output logic [CADDR_W-1:0] o_cache_data_addr,
  input  logic [DATA_W-1:0]  i_cache_data_dout,
  output logic [MADDR_W-1:0] o_main_mem_addr,
  output logic [DATA_W-1:0]  o_main_mem_din,
  output logic               o_main_mem_we,
  output logic               o_busy,
  output logic               o_done
);

  wb_state_e           r_state;
  wb_state_e           w_state_nxt;
  logic [WORD_W-1:0]   r_cnt;
  logic [TAG_W-1:0]    r_tag_q;
  logic [INDEX_W-1:0]  r_index_q;
  logic [CADDR_W-1:0]  r_cache_addr;
  logic [MADDR_W-1:0]  r_mem_addr;
  logic                r_we;
  logic                r_done;

  logic [WORD_W-1:0]   w_cnt_nxt;
  logic [WORD_W-1:0]   w_cnt_p1;
  logic [WORD_W-1:0]   w_cnt_p2;
  logic [TAG_W-1:0]    w_tag_nxt;
  logic [INDEX_W-1:0]  w_idx_nxt;
  logic [CADDR_W-1:0]  w_caddr_nxt;
  logic [MADDR_W-1:0]  w_maddr_nxt;
  logic                w_we_nxt;
  logic                w_done_nxt;
  logic                w_last;
  logic                w_clean_skip;

`ifdef CACHE_WB_CLEAN_SKIP_EN
  assign w_clean_skip = ~i_dirty;
`else
  logic w_unused_dirty;
  assign w_unused_dirty = i_dirty;
  assign w_clean_skip   = 1'b0;
`endif

  assign w_cnt_p1 = r_cnt + WORD_W'(1);
  assign w_cnt_p2 = r_cnt + WORD_W'(2);
  assign w_last   = (r_cnt == LAST_WORD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= WB_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE:  if (i_start) w_state_nxt = w_clean_skip ? WB_DONE : WB_PRIME;
      WB_PRIME: w_state_nxt = WB_WRITE;
      WB_WRITE: if (w_last) w_state_nxt = WB_DONE;
      WB_DONE:  w_state_nxt = WB_IDLE;
      default:  w_state_nxt = WB_IDLE;
    endcase
  end

  // Cache address runs one word ahead of memory to cover the 1-cycle read latency.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_tag_nxt   = r_tag_q;
    w_idx_nxt   = r_index_q;
    w_caddr_nxt = r_cache_addr;
    w_maddr_nxt = r_mem_addr;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      WB_IDLE: begin
        w_cnt_nxt = '0;
        if (i_start && !w_clean_skip) begin
          w_tag_nxt   = i_victim_tag;
          w_idx_nxt   = i_index;
          w_caddr_nxt = {i_index, WORD_W'(0)};
        end
      end
      WB_PRIME: begin
        w_cnt_nxt   = '0;
        w_caddr_nxt = {r_index_q, WORD_W'(1)};
        w_maddr_nxt = {r_tag_q, r_index_q, WORD_W'(0)};
        w_we_nxt    = 1'b1;
      end
      WB_WRITE: begin
        w_cnt_nxt   = w_cnt_p1;
        w_caddr_nxt = {r_index_q, w_cnt_p2};
        w_maddr_nxt = {r_tag_q, r_index_q, w_cnt_p1};
        w_we_nxt    = ~w_last;
      end
      WB_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_tag_q      <= '0;
      r_index_q    <= '0;
      r_cache_addr <= '0;
      r_mem_addr   <= '0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_tag_q      <= w_tag_nxt;
      r_index_q    <= w_idx_nxt;
      r_cache_addr <= w_caddr_nxt;
      r_mem_addr   <= w_maddr_nxt;
      r_we         <= w_we_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign o_cache_data_addr = r_cache_addr;
  assign o_main_mem_addr   = r_mem_addr;
  assign o_main_mem_din    = i_cache_data_dout;
  assign o_main_mem_we     = r_we;
  assign o_done            = r_done;
  assign o_busy            = (r_state != WB_IDLE);

endmodule

// File: tb/tb_cache_writeback.sv
// Self-checking bench for cache_writeback: vector table, corner sequences, random model.
`timescale 1ns/1ps
module tb_cache_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dirty;
  logic [3:0]  victim_tag;
  logic [5:0]  index;
  logic [8:0]  cache_addr;
  logic [31:0] cache_dout;
  logic [12:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] cache_mem [512];
  logic [12:0] obs_addr [$];
  logic [31:0] obs_data [$];
  int          done_cnt = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [5:0]  idx;
    logic        dirty;
    logic [12:0] base;
    bit          skip;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  cache_writeback dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start           (start),
    .i_victim_tag      (victim_tag),
    .i_index           (index),
    .i_dirty           (dirty),
    .o_cache_data_addr (cache_addr),
    .i_cache_data_dout (cache_dout),
    .o_main_mem_addr   (mem_addr),
    .o_main_mem_din    (mem_din),
    .o_main_mem_we     (mem_we),
    .o_busy            (busy),
    .o_done            (done)
  );

  // cache data array: synchronous read, one cycle of latency
  always @(posedge clk) cache_dout <= cache_mem[cache_addr];

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_din);
    end
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_caddr"}, 32'(cache_addr), 32'h0);
    chk({nm, "_maddr"}, 32'(mem_addr), 32'h0);
    chk({nm, "_we"},    32'(mem_we), 32'h0);
    chk({nm, "_done"},  32'(done), 32'h0);
    chk({nm, "_busy"},  32'(busy), 32'h0);
  endtask

  // One start pulse, then cycle-by-cycle comparison against the documented timeline.
  task automatic run_vec(input int v, input logic [3:0] tg, input logic [5:0] ix,
                         input logic dt, input logic [12:0] base, input bit skip);
    logic [2:0]  k;
    logic        exp_we;
    logic        exp_done;
    logic        exp_busy;
    @(negedge clk);
    victim_tag = tg; index = ix; dirty = dt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; victim_tag = ~tg; index = ~ix; dirty = ~dt;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk);
      k = 3'(j - 1);
      if (skip) begin
        exp_we = 1'b0; exp_done = (j == 1); exp_busy = (j == 0);
      end else begin
        exp_we = (j >= 1 && j <= 8); exp_done = (j == 10); exp_busy = (j <= 9);
      end
      chk($sformatf("v%0d_c%0d_we", v, j),   32'(mem_we), 32'(exp_we));
      chk($sformatf("v%0d_c%0d_done", v, j), 32'(done),   32'(exp_done));
      chk($sformatf("v%0d_c%0d_busy", v, j), 32'(busy),   32'(exp_busy));
      if (exp_we) begin
        chk($sformatf("v%0d_c%0d_addr", v, j), 32'(mem_addr), 32'(base + 13'(j - 1)));
        chk($sformatf("v%0d_c%0d_data", v, j), mem_din, cache_mem[{ix, k}]);
      end
    end
  endtask

  initial begin
    int          dc0;
    int          spur;
    int          nexp;
    bit          seen;
    logic [3:0]  tg;
    logic [5:0]  ix;
    logic        dt;
    logic [12:0] exp_addr [$];
    logic [31:0] exp_data [$];

    rst_n = 1'b0; start = 1'b0; dirty = 1'b1; victim_tag = '0; index = '0;
    for (int i = 0; i < 512; i++) cache_mem[i] = $urandom;
    for (int i = 0; i < 8; i++) cache_mem[{6'h05, 3'(i)}] = 32'h100 + 32'(i);

    vecs[0] = '{4'hA, 6'h05, 1'b1, 13'h1428, 1'b0};
    vecs[1] = '{4'h0, 6'h00, 1'b1, 13'h0000, 1'b0};
    vecs[2] = '{4'hF, 6'h3F, 1'b1, 13'h1FF8, 1'b0};
    vecs[3] = '{4'h3, 6'h2A, 1'b1, 13'h0750, 1'b0};
    vecs[4] = '{4'h5, 6'h11, 1'b1, 13'h0A88, 1'b0};
`ifdef CACHE_WB_CLEAN_SKIP_EN
    vecs[5] = '{4'h6, 6'h0C, 1'b0, 13'h0C60, 1'b1};
`else
    vecs[5] = '{4'h6, 6'h0C, 1'b0, 13'h0C60, 1'b0};
`endif

    // reset while idle, then idle with no start
    #12;
    chk_quiet("rst_idle");
    @(negedge clk); rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk_quiet($sformatf("post_rst_c%0d", j));
    end

    for (int v = 0; v < 6; v++)
      run_vec(v, vecs[v].tag, vecs[v].idx, vecs[v].dirty, vecs[v].base, vecs[v].skip);

    // start during WRITE with a different line is ignored
    @(posedge clk); #1;
    obs_addr.delete(); obs_data.delete(); dc0 = done_cnt;
    @(negedge clk); victim_tag = 4'hA; index = 6'h05; dirty = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 3) begin start = 1'b1; victim_tag = 4'h2; index = 6'h3F; end
      if (j == 4) start = 1'b0;
    end
    @(posedge clk); #1;
    chk("ign_nwrites", 32'(obs_addr.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
      chk($sformatf("ign_addr%0d", i), 32'(obs_addr[i]), 32'h1428 + 32'(i));
      chk($sformatf("ign_data%0d", i), obs_data[i], 32'h100 + 32'(i));
    end
    chk("ign_ndone", 32'(done_cnt - dc0), 32'd1);

    // start held high: back-to-back transfers
    obs_addr.delete(); obs_data.delete(); dc0 = done_cnt;
    @(negedge clk); victim_tag = 4'h3; index = 6'h2A; dirty = 1'b1; start = 1'b1;
    for (int j = 0; j <= 21; j++) begin
      @(negedge clk);
      if (j == 12) begin
        chk("b2b_second_we", 32'(mem_we), 32'd1);
        chk("b2b_second_addr", 32'(mem_addr), 32'h0750);
      end
      if (j == 21) start = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_nwrites", 32'(obs_addr.size()), 32'd16);
    chk("b2b_ndone", 32'(done_cnt - dc0), 32'd2);

    // asynchronous reset after the third write
    obs_addr.delete(); obs_data.delete(); dc0 = done_cnt;
    @(negedge clk); victim_tag = 4'hA; index = 6'h05; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    @(posedge clk); #1;
    chk("rst_nwrites", 32'(obs_addr.size()), 32'd3);
    chk("rst_ndone", 32'(done_cnt - dc0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // random transfers against a line-level model
    for (int i = 0; i < 512; i++) cache_mem[i] = $urandom;
    obs_addr.delete(); obs_data.delete(); dc0 = done_cnt;
    for (int t = 0; t < 20; t++) begin
      tg = 4'($urandom); ix = 6'($urandom); dt = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk); victim_tag = tg; index = ix; dirty = dt; start = 1'b1;
      nexp = 8;
`ifdef CACHE_WB_CLEAN_SKIP_EN
      if (!dt) nexp = 0;
`endif
      for (int k = 0; k < nexp; k++) begin
        exp_addr.push_back({tg, ix, 3'(k)});
        exp_data.push_back(cache_mem[{ix, 3'(k)}]);
      end
      spur = (nexp == 0) ? 0 : $urandom_range(1, 8);
      @(negedge clk); start = 1'b0; victim_tag = 4'($urandom); index = 6'($urandom);
      seen = 1'b0;
      for (int j = 1; j <= 20 && !seen; j++) begin
        @(negedge clk);
        start = (j == spur);
        if (j == spur) begin victim_tag = 4'($urandom); index = 6'($urandom); end
        if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk($sformatf("rnd%0d_done_seen", t), 32'(seen), 32'd1);
    end
    @(posedge clk); #1;
    chk("rnd_nwrites", 32'(obs_addr.size()), 32'(exp_addr.size()));
    chk("rnd_ndone", 32'(done_cnt - dc0), 32'd20);
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      chk($sformatf("rnd_addr%0d", i), 32'(obs_addr[i]), 32'(exp_addr[i]));
      chk($sformatf("rnd_data%0d", i), obs_data[i], exp_data[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
